// File: rtl/cqu_mips_pkg.sv
// Shared types for the data-memory responder.
// Holds the word/strobe widths and the FSM state encoding.
package cqu_mips_pkg;
   localparam int WORD_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;
endpackage

// File: rtl/sram_1rw.sv
// Single-port word SRAM with synchronous read and per-byte writes.
// Contents are not reset; rdata_o only updates on enabled reads.
module sram_1rw
   import cqu_mips_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [STRB_W-1:0] wstrb_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int i = 0; i < STRB_W; i++) begin
               if (wstrb_i[i]) begin
                  mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
               end
            end
         end else begin
            rdata_o <= mem_q[addr_i];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one outstanding request,
// fixed wait states, error check on alignment and range.
module data_mem_responder
   import cqu_mips_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_stall
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT =
      (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, err_q;
   logic [AW-1:0]     idx_q;
   logic [WORD_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;

   logic              idle, accept, err_in, enter_resp;
   logic              sel_we, sel_err;
   logic [AW-1:0]     sel_idx;
   logic [WORD_W-1:0] sel_wdata, sram_rdata;
   logic [STRB_W-1:0] sel_wstrb;

   assign idle   = (state_q == ST_IDLE);
   assign err_in = (req_addr[1:0] != 2'b00) ||
                   (req_addr[31:2] >= 30'(DEPTH));

   assign req_ready = idle && rstn;
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
               cnt_d   = CNT_INIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // With zero wait states the access lands on the accepting edge,
   // so the SRAM must see the live request rather than the latch.
   assign sel_we    = idle ? req_we    : we_q;
   assign sel_err   = idle ? err_in    : err_q;
   assign sel_idx   = idle ? req_addr[AW+1:2] : idx_q;
   assign sel_wdata = idle ? req_wdata : wdata_q;
   assign sel_wstrb = idle ? req_wstrb : wstrb_q;

   assign enter_resp = rstn && (state_d == ST_RESP) &&
                       (state_q != ST_RESP);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= req_we;
            err_q   <= err_in;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
         end
      end
   end

   sram_1rw #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sram (
      .clk_i   (clk),
      .en_i    (enter_resp && !sel_err),
      .we_i    (sel_we),
      .addr_i  (sel_idx),
      .wdata_i (sel_wdata),
      .wstrb_i (sel_wstrb),
      .rdata_o (sram_rdata)
   );

   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !we_q) ?
                       sram_rdata : '0;

   assign mem_stall = rstn &&
      ((state_q == ST_WAIT) ||
       (resp_valid && !resp_ready) ||
       (idle && req_valid));

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench: a 2-wait-state instance for the main
// sequence and a zero-wait instance for back-to-back throughput.
module tb_data_mem_responder;

   localparam int DEPTH = 1024;
   localparam int W     = 2;
   localparam int D0    = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata, resp_rdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_err, mem_stall;

   logic        z_req_valid, z_req_ready, z_req_we;
   logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
   logic [3:0]  z_req_wstrb;
   logic        z_resp_valid, z_resp_ready, z_resp_err, z_mem_stall;

   int total = 0;
   int bad   = 0;

   logic [32:0] q[$];
   logic [32:0] zq[$];
   logic [31:0] model[int];
   logic [31:0] zmodel[int];

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_stall(mem_stall)
   );

   data_mem_responder #(.DEPTH(D0), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rstn(rstn),
      .req_valid(z_req_valid), .req_ready(z_req_ready),
      .req_we(z_req_we), .req_addr(z_req_addr),
      .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
      .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
      .mem_stall(z_mem_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] wd, input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic is_err(input logic [31:0] a,
                                   input int depth);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'(depth));
   endfunction

   task automatic access(input logic we, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] st,
      input int hold, input string tag);
      logic [32:0] e;
      int          lat;
      int          k;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      req_wstrb = st;
      lat = 0;
      while (!req_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("%s.ready", tag), 32'(req_ready), 32'd1);
      k = int'(a[31:2]);
      if (is_err(a, DEPTH)) begin
         e = {1'b1, 32'h0};
      end else if (we) begin
         model[k] = merge(model.exists(k) ? model[k] : 32'h0, wd, st);
         e = {1'b0, 32'h0};
      end else begin
         e = {1'b0, model[k]};
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      lat = 1;
      while (!resp_valid && lat < 20) begin
         chk($sformatf("%s.wstall", tag), 32'(mem_stall), 32'd1);
         @(posedge clk);
         #1;
         lat++;
      end
      chk($sformatf("%s.latency", tag), 32'(lat), 32'(1 + W));
      chk($sformatf("%s.qsize", tag), 32'(q.size()), 32'd1);
      e = (q.size() > 0) ? q.pop_front() : 33'h0;
      chk($sformatf("%s.rdata", tag), resp_rdata, e[31:0]);
      chk($sformatf("%s.err", tag), 32'(resp_err), 32'(e[32]));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s.hvalid", tag), 32'(resp_valid), 32'd1);
         chk($sformatf("%s.hrdata", tag), resp_rdata, e[31:0]);
         chk($sformatf("%s.hstall", tag), 32'(mem_stall), 32'd1);
         chk($sformatf("%s.hready", tag), 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      #1;
      chk($sformatf("%s.rready", tag), 32'(req_ready), 32'd0);
      chk($sformatf("%s.rstall", tag), 32'(mem_stall), 32'd0);
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk($sformatf("%s.done", tag), 32'(resp_valid), 32'd0);
      chk($sformatf("%s.idle", tag), 32'(req_ready), 32'd1);
   endtask

   task automatic zdrive(input int k);
      z_req_valid = (k < 9);
      z_req_wstrb = 4'hF;
      z_req_wdata = 32'hA500_0000 + 32'(k);
      if (k < 4) begin
         z_req_we   = 1'b1;
         z_req_addr = 32'(4 * k);
      end else if (k < 8) begin
         z_req_we   = 1'b0;
         z_req_addr = 32'(4 * (k - 4));
      end else begin
         z_req_we   = 1'b0;
         z_req_addr = 32'(4 * D0);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      chk($sformatf("%s.rdy", tag), 32'(req_ready), 32'd0);
      chk($sformatf("%s.stall", tag), 32'(mem_stall), 32'd0);
      chk($sformatf("%s.valid", tag), 32'(resp_valid), 32'd0);
      chk($sformatf("%s.rdata", tag), resp_rdata, 32'd0);
      chk($sformatf("%s.err", tag), 32'(resp_err), 32'd0);
   endtask

   initial begin
      int          n;
      int          got;
      int          cyc;
      int          last;
      bit          acc;
      logic [32:0] e;

      rstn         = 1'b0;
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_addr     = 32'h10;
      req_wdata    = 32'h0;
      req_wstrb    = 4'h0;
      resp_ready   = 1'b0;
      z_resp_ready = 1'b1;
      zdrive(0);
      z_req_valid  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outs("rst");
      req_valid = 1'b0;
      rstn      = 1'b1;
      @(negedge clk);
      chk("rst.idle", 32'(req_ready), 32'd1);

      access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "st10");
      access(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10");
      access(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, "stb0");
      access(1'b0, 32'h10, 32'h0, 4'h3, 0, "ldb0");
      access(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, "stz");
      access(1'b0, 32'h10, 32'h0, 4'hF, 0, "ldz");
      access(1'b1, 32'hFFC, 32'h1357_9BDF, 4'hF, 0, "sttop");
      access(1'b0, 32'h13, 32'h0, 4'h0, 0, "ldmis");
      access(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 0, "ldoor");
      access(1'b1, 32'h11, 32'h5555_5555, 4'hF, 0, "stmis");
      access(1'b1, 32'(DEPTH * 4), 32'h6666_6666, 4'hF, 0, "stoor");
      access(1'b0, 32'h10, 32'h0, 4'h0, 0, "ldchk");
      access(1'b0, 32'hFFC, 32'h0, 4'h0, 0, "ldtop");
      access(1'b0, 32'h10, 32'h0, 4'h0, 5, "hold");

      access(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, "st20");
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h1234_5678;
      req_wstrb = 4'hF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outs("wrst");
      @(posedge clk);
      @(negedge clk);
      check_reset_outs("wrst2");
      rstn = 1'b1;
      access(1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20");

      n    = 0;
      got  = 0;
      cyc  = 0;
      last = 0;
      zdrive(0);
      for (int it = 0; it < 60 && got < 9; it++) begin
         @(negedge clk);
         acc = z_req_valid && z_req_ready;
         if (acc) begin
            if (is_err(z_req_addr, D0)) begin
               zq.push_back({1'b1, 32'h0});
            end else if (z_req_we) begin
               zmodel[int'(z_req_addr[31:2])] = z_req_wdata;
               zq.push_back({1'b0, 32'h0});
            end else begin
               zq.push_back({1'b0, zmodel[int'(z_req_addr[31:2])]});
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            n++;
            zdrive(n);
         end
         if (z_resp_valid) begin
            got++;
            if (got > 1)
               chk("z.interval", 32'(cyc - last), 32'd2);
            last = cyc;
            chk("z.spurious", 32'(zq.size() > 0), 32'd1);
            e = (zq.size() > 0) ? zq.pop_front() : 33'h0;
            chk("z.rdata", z_resp_rdata, e[31:0]);
            chk("z.err", 32'(z_resp_err), 32'(e[32]));
         end
      end
      chk("z.count", 32'(got), 32'd9);
      chk("z.leftover", 32'(zq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, memory size in 32-bit words (power of two, 16..65536).
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait states per access (0..15).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rstn  input  1  reset; synchronous, active-low.
REQ-005 Port req_valid  input  1  pipeline MEM stage presents a request.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data.
REQ-010 Port req_wstrb  input  4  store byte enables; bit i writes byte i (little-endian).
REQ-011 Port resp_valid  output  1  response available.
REQ-012 Port resp_ready  input  1  pipeline consumes response.
REQ-013 Port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 Port resp_err  output  1  request was misaligned or out of range.
REQ-015 Port mem_stall  output  1  stall request to the pipeline stall chain.

Function
REQ-016 FSM states IDLE, WAIT, RESP; one outstanding request at most.
REQ-017 req_ready SHALL equal (state == IDLE) and rstn high; accept = req_valid && req_ready.
REQ-018 On accept: latch we/addr/wdata/wstrb; WAIT_CYCLES=0 -> RESP next; else WAIT with counter = WAIT_CYCLES-1.
REQ-019 WAIT: counter decrements each cycle; at counter 0 -> RESP next cycle.
REQ-020 Memory access (read sample or strobed write) SHALL occur on the edge entering RESP; resp_valid rises exactly 1+WAIT_CYCLES edges after the accepting edge.
REQ-021 RESP: resp_valid, resp_rdata, resp_err held stable until resp_ready high; that edge -> IDLE.
REQ-022 req_ready is 0 in RESP even when resp_ready is high; next request accepted no earlier than the following cycle.
REQ-023 Error when addr[1:0] != 0 or addr[31:2] >= DEPTH: no memory change, resp_err=1, resp_rdata=0, same latency.
REQ-024 Store with wstrb=4'b0000: no memory change, resp_err=0.
REQ-025 Load ignores req_wstrb; resp_rdata is the full word.
REQ-026 mem_stall = (state==WAIT) || (state==RESP && !resp_ready) || (state==IDLE && req_valid).
REQ-027 Request inputs are ignored outside the accepting cycle.

Reset
REQ-028 rstn low at a clock edge: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready and mem_stall are 0 while rstn is low.
REQ-029 Reset during WAIT aborts the request; a pending store SHALL NOT modify memory.
REQ-030 Memory contents are not cleared by reset.

Structure
REQ-031 Shared package cqu_mips_pkg holds the FSM state enum, WORD_W=32, STRB_W=4.
REQ-032 One sub-module sram_1rw: single-port, DEPTH words, synchronous read, per-byte write enable.
REQ-033 Target size 120-400 lines RTL total.

Verification
REQ-034 WAIT_CYCLES=2: store 0xDEADBEEF at 0x10, wstrb=4'hF, then load 0x10 -> resp_valid 3 edges after each accept, rdata=0xDEADBEEF, err=0.
REQ-035 Partial store 0x000000AA at 0x10, wstrb=4'b0001, over 0xDEADBEEF -> load returns 0xDEADBEAA.
REQ-036 Load at 0x13 and at DEPTH*4 -> resp_err=1, rdata=0; memory unchanged on follow-up aligned loads.
REQ-037 resp_ready held low 5 cycles in RESP -> resp_valid/rdata stable, mem_stall=1, req_ready=0 throughout.
REQ-038 rstn low during WAIT of store 0x12345678 to 0x20 -> after reset load 0x20 returns prior value; all outputs at reset values.
REQ-039 WAIT_CYCLES=0 back-to-back loads with resp_ready tied high -> one response every 2 cycles, no lost or duplicated response.
